// File: rtl/fp_pkg.sv
// Shared constants and FSM encoding for the floating-point adder datapath.
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    // Extended mantissa layout: carry, hidden, fraction, guard/round/sticky.
    localparam int CARRY_BIT  = 27;
    localparam int HIDDEN_BIT = 26;
    localparam int G_BIT      = 2;
    localparam int R_BIT      = 1;
    localparam int S_BIT      = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_PACK  = 2'd3
    } state_t;

endpackage

// File: rtl/lzc27.sv
// Combinational leading-zero counter over a 27-bit mantissa (count 27 when all zero).
module lzc27 (
    input  logic [26:0] value,
    output logic [4:0]  count,
    output logic        all_zero
);

    // The highest set bit is visited last, so it decides the count.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value[i]) count = 5'(26 - i);
        end
    end

    assign all_zero = ~|value;

endmodule

// File: rtl/fp_norm_round.sv
// Normalise, round-to-nearest-even and pack stage of the single-precision adder.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int MWIDTH = 28
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              start,
    input  logic              sign_in,
    input  logic [9:0]        exp_in,
    input  logic [MWIDTH-1:0] mant_in,
    input  logic              nan_in,
    input  logic              inf_in,
    output logic [DWIDTH-1:0] result,
    output logic              done,
    output logic              busy
);

    state_t state, state_next;

    logic              sign_r, nan_r, inf_r, zero_r;
    logic [9:0]        exp_r;
    logic [MWIDTH-1:0] mant_r;

    // NORM datapath
    logic [4:0]         lz;
    logic               lz_zero;
    logic signed [10:0] exp_ext, norm_e, under;
    logic [4:0]         sh;
    logic [27:0]        norm_mant, drop_mask;
    logic               norm_zero, sticky;

    // ROUND datapath
    logic        rnd_inc;
    logic [24:0] rnd_sum;
    logic [23:0] rnd_sig;
    logic [9:0]  rnd_exp;

    logic [31:0] pack_word;

    lzc27 u_lzc (
        .value    (mant_r[HIDDEN_BIT:0]),
        .count    (lz),
        .all_zero (lz_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first;
    // a missed branch would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_NORM;
            ST_NORM:  state_next = ST_ROUND;
            ST_ROUND: state_next = ST_PACK;
            ST_PACK:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    assign exp_ext = {exp_r[9], exp_r};

    always_comb begin
        norm_mant = mant_r;
        norm_e    = exp_ext;
        norm_zero = 1'b0;
        under     = '0;
        sh        = '0;
        drop_mask = '0;
        sticky    = 1'b0;
        if (mant_r[CARRY_BIT]) begin
            norm_mant = {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
            norm_e    = exp_ext + 11'sd1;
        end else if (lz_zero) begin
            norm_zero = 1'b1;
        end else begin
            norm_mant = mant_r << lz;
            norm_e    = exp_ext - $signed({6'b0, lz});
        end
        // Gradual underflow: denormalise so the exponent field reads zero.
        if (!norm_zero && norm_e <= 11'sd0) begin
            under     = 11'sd1 - norm_e;
            sh        = (under > 11'sd27) ? 5'd27 : under[4:0];
            drop_mask = (28'd1 << sh) - 28'd1;
            sticky    = |(norm_mant & drop_mask);
            norm_mant = (norm_mant >> sh) | {27'b0, sticky};
            norm_e    = '0;
        end
    end

    always_comb begin
        rnd_inc = mant_r[G_BIT] & (mant_r[R_BIT] | mant_r[S_BIT] | mant_r[3]);
        rnd_sum = {1'b0, mant_r[HIDDEN_BIT:3]} + {24'b0, rnd_inc};
        rnd_sig = rnd_sum[23:0];
        rnd_exp = exp_r;
        if (rnd_sum[24]) begin
            rnd_sig = rnd_sum[24:1];
            rnd_exp = exp_r + 10'd1;
        end else if (exp_r == 10'd0 && rnd_sum[23]) begin
            rnd_exp = 10'd1;
        end
    end

    always_comb begin
        if (nan_r)
            pack_word = QNAN;
        else if (inf_r)
            pack_word = POS_INF | {sign_r, 31'b0};
        else if (zero_r)
            pack_word = {sign_r, 31'b0};
        else if (int'($signed(exp_r)) >= EXP_MAX)
            pack_word = POS_INF | {sign_r, 31'b0};
        else
            pack_word = {sign_r, exp_r[EXP_W-1:0], mant_r[FRAC_W+2:3]};
    end

    // NOTE: every datapath register is reset, so an aborted operation
    // leaves nothing behind for the next one to pick up.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            sign_r <= 1'b0;
            nan_r  <= 1'b0;
            inf_r  <= 1'b0;
            zero_r <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == ST_PACK);
            unique case (state)
                ST_IDLE: if (start) begin
                    sign_r <= sign_in;
                    exp_r  <= exp_in;
                    mant_r <= mant_in;
                    nan_r  <= nan_in;
                    inf_r  <= inf_in;
                    zero_r <= 1'b0;
                end
                ST_NORM: begin
                    mant_r <= norm_mant;
                    exp_r  <= norm_e[9:0];
                    zero_r <= norm_zero;
                end
                ST_ROUND: begin
                    mant_r <= {1'b0, rnd_sig, 3'b000};
                    exp_r  <= rnd_exp;
                end
                ST_PACK: result <= pack_word;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed-vector bench for fp_norm_round: latency, handshake, rounding and specials.
module tb_fp_norm_round;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rest = 1'b0;
    logic        start = 1'b0;
    logic        sign_in = 1'b0;
    logic [9:0]  exp_in = '0;
    logic [27:0] mant_in = '0;
    logic        nan_in = 1'b0;
    logic        inf_in = 1'b0;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    fp_norm_round #(.DWIDTH(32), .MWIDTH(28)) dut (
        .clk     (clk),
        .rest    (rest),
        .start   (start),
        .sign_in (sign_in),
        .exp_in  (exp_in),
        .mant_in (mant_in),
        .nan_in  (nan_in),
        .inf_in  (inf_in),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) for done; lat = 0 means timeout.
    task automatic run_op(input logic s, input logic [9:0] e, input logic [27:0] m,
                          input logic n, input logic f,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        @(negedge clk);
        sign_in = s; exp_in = e; mant_in = m; nan_in = n; inf_in = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0; res = '0;
        for (int i = 1; i <= 10; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want %h", result, 32'h0); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        rest = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] r; int lat, bc;
        run_op(1'b0, 10'(EXP_BIAS), 28'h4000000, 1'b0, 1'b0, r, lat, bc);
        n_cmp++; if (r !== 32'h3F800000) begin n_bad++; $display("FAIL one_result: got %h want %h", r, 32'h3F800000); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL one_latency: got %0d want 3", lat); end
        n_cmp++; if (bc !== 3) begin n_bad++; $display("FAIL one_busy_cycles: got %0d want 3", bc); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_in_done_cycle: got %b want 0", busy); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %b want 0", done); end
        n_cmp++; if (result !== 32'h3F800000) begin n_bad++; $display("FAIL result_held: got %h want %h", result, 32'h3F800000); end
    endtask

    task automatic test_normalise();
        logic [9:0]  e_v [4] = '{10'd127, 10'd127, 10'd254, 10'd1};
        logic [27:0] m_v [4] = '{28'hC000000, 28'h0000008, 28'h7FFFFFF, 28'h2000000};
        logic [31:0] x_v [4] = '{32'h40400000, 32'h34000000, 32'h7F800000, 32'h00400000};
        logic [31:0] r; int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, e_v[i], m_v[i], 1'b0, 1'b0, r, lat, bc);
            n_cmp++;
            if (r !== x_v[i] || lat !== 3) begin
                n_bad++;
                $display("FAIL norm_vec%0d: got %h lat %0d want %h lat 3", i, r, lat, x_v[i]);
            end
        end
    endtask

    task automatic test_rne();
        logic [27:0] m_v [3] = '{28'h4000004, 28'h400000C, 28'h4000005};
        logic [31:0] x_v [3] = '{32'h3F800000, 32'h3F800002, 32'h3F800001};
        logic [31:0] r; int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, 10'd127, m_v[i], 1'b0, 1'b0, r, lat, bc);
            n_cmp++;
            if (r !== x_v[i]) begin
                n_bad++;
                $display("FAIL rne_vec%0d: got %h want %h", i, r, x_v[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] r; int lat, bc;
        run_op(1'b1, 10'd0, 28'h0, 1'b0, 1'b0, r, lat, bc);
        n_cmp++; if (r !== 32'h80000000) begin n_bad++; $display("FAIL neg_zero: got %h want %h", r, 32'h80000000); end
        run_op(1'b1, 10'd127, 28'h4000000, 1'b1, 1'b1, r, lat, bc);
        n_cmp++; if (r !== 32'h7FC00000) begin n_bad++; $display("FAIL nan_priority: got %h want %h", r, 32'h7FC00000); end
        run_op(1'b1, 10'd127, 28'h4000000, 1'b0, 1'b1, r, lat, bc);
        n_cmp++; if (r !== 32'hFF800000) begin n_bad++; $display("FAIL neg_inf: got %h want %h", r, 32'hFF800000); end
    endtask

    task automatic test_start_held();
        int n_done = 0;
        @(negedge clk);
        sign_in = 1'b0; exp_in = 10'd127; mant_in = 28'h4000000; nan_in = 1'b0; inf_in = 1'b0;
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        if (done) n_done++;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL start_held_dones: got %0d want 1", n_done); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat, bc, lat2;
        run_op(1'b0, 10'd128, 28'h4000000, 1'b0, 1'b0, r, lat, bc);
        // Still in the done cycle: a new start here must be accepted.
        exp_in = 10'd128; mant_in = 28'h6000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat2 = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (done) begin lat2 = i; break; end
        end
        n_cmp++; if (lat2 !== 3) begin n_bad++; $display("FAIL b2b_latency: got %0d want 3", lat2); end
        n_cmp++; if (result !== 32'h40400000) begin n_bad++; $display("FAIL b2b_result: got %h want %h", result, 32'h40400000); end
    endtask

    task automatic test_abort();
        logic [31:0] r; int lat, bc, n_done;
        @(negedge clk);
        sign_in = 1'b1; exp_in = 10'd130; mant_in = 28'h5000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rest = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL abort_result: got %h want %h", result, 32'h0); end
        @(negedge clk);
        rest = 1'b1;
        n_done = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
        run_op(1'b0, 10'd128, 28'h4000000, 1'b0, 1'b0, r, lat, bc);
        n_cmp++; if (r !== 32'h40000000) begin n_bad++; $display("FAIL after_abort_result: got %h want %h", r, 32'h40000000); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL after_abort_latency: got %0d want 3", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_normalise();
        test_rne();
        test_specials();
        test_start_held();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
